seg7_scan_decoder: RTL
======================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits observed.
REQ-002 Parameter STABLE_CYCLES, default 4, legal range 2..255: consecutive identical samples required before a capture.
REQ-003 Port clk  input  1: single clock; all logic on the rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port an  input  N_DIGITS: active-low digit select; an[i]=0 selects digit i.
REQ-006 Port seg  input  8: active-low segment code; bit 7 is dp, bits 6:0 are g..a.
REQ-007 Port digits  output  4*N_DIGITS: decoded hex value of digit i on bits [4i+3:4i].
REQ-008 Port dp  output  N_DIGITS: decimal point of digit i, 1 = lit.
REQ-009 Port valid  output  N_DIGITS: digit i holds a legal hex glyph.
REQ-010 Port err  output  N_DIGITS: the last capture of digit i was neither a legal glyph nor blank.
REQ-011 Port frame_done  output  1: one-cycle pulse; every digit has been captured since the previous pulse.

Function
REQ-012 {an, seg} SHALL be registered once per cycle into a sample register; all decisions use registered samples only.
REQ-013 A sample is "selectable" only when exactly one bit of the registered an is 0; all-ones or multi-zero an SHALL clear the stability counter, and no capture occurs.
REQ-014 The stability counter SHALL reset to 1 when the new sample differs from the previous one, and SHALL otherwise increment, saturating at STABLE_CYCLES.
REQ-015 A capture SHALL occur on the edge at which the counter reaches STABLE_CYCLES with a selectable sample, exactly once per stable window; no recapture until the sample changes.
REQ-016 With inputs held constant, the outputs SHALL update on the (STABLE_CYCLES+1)th rising edge after the inputs settle.
REQ-017 Decode seg[6:0] with the inverse of the team hex glyph table: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (bit 7 treated as 1).
REQ-018 Legal glyph captured: digits slot = value, valid=1, err=0.
REQ-019 Blank (seg[6:0]=7F) captured: valid=0, err=0, digits slot unchanged.
REQ-020 Any other code captured: valid=0, err=1, digits slot unchanged.
REQ-021 dp[i] SHALL be set to ~seg[7] on every capture of digit i, whatever the glyph class.
REQ-022 A per-digit "seen" bit SHALL set on capture; when all are set, frame_done SHALL pulse on the same edge as the completing capture, and all seen bits SHALL clear on that edge.
REQ-023 A capture of an already-seen digit SHALL update its outputs without affecting frame_done.
REQ-024 Outputs of non-captured digits SHALL hold their values.

Reset
REQ-025 On rst: digits=0, dp=0, valid=0, err=0, frame_done=0, sample register=all ones, counter=0, seen bits=0.
REQ-026 Reset asserted mid-window SHALL abort that window; the next capture requires a full STABLE_CYCLES window after rst deasserts.
REQ-027 rst SHALL take priority over any capture on the same edge.

Structure
REQ-028 The glyph constants (16 codes, BLANK=8'hFF), the default N_DIGITS and the default STABLE_CYCLES SHALL live in shared package seg7_pkg, which the existing encoder also uses.
REQ-029 Glyph-to-nibble inversion SHALL be a combinational sub-module seg7_to_hex (in: 7-bit code; out: 4-bit value, legal, blank).
REQ-030 The counter width SHALL be $clog2(STABLE_CYCLES+1).

Verification (STABLE_CYCLES=4)
REQ-031 an=1110, seg=C0 held 10 cycles -> digits[3:0]=0, valid[0]=1, err[0]=0 after 5th edge; single capture only.
REQ-032 an=1101, seg=F9 for 2 cycles then A4 held -> no capture of 1; digit1=2 on 5th edge after the change.
REQ-033 Scan digits 0..3 with codes F9, A4, 30 (3 with dp), 88, each held 6 cycles -> digits=16'hA321, dp=0100, valid=1111, exactly one frame_done pulse.
REQ-034 an=1110, seg=8C held -> err[0]=1, valid[0]=0, digits[3:0] unchanged; then seg=FF -> err[0]=0, valid[0]=0.
REQ-035 an=1100 or 1111 with seg=C0 held 10 cycles -> no output change, frame_done=0.
REQ-036 rst pulsed on cycle 3 of a window -> all outputs 0; capture 5 edges after rst deasserts.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: hex glyph table, blank code and the
// default geometry used by both the scan encoder and the scan decoder.
package seg7_pkg;

  localparam int unsigned N_DIGITS_DEF      = 4;
  localparam int unsigned STABLE_CYCLES_DEF = 4;

  // Active-low codes with dp off (bit 7 = 1); index is the hex value.
  localparam logic [7:0] GLYPH_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  localparam logic [7:0] BLANK = 8'hFF;

  typedef enum logic [1:0] {
    GLYPH_LEGAL,
    GLYPH_BLANK,
    GLYPH_ILLEGAL
  } glyph_class_t;

  function automatic glyph_class_t glyph_classify(input logic legal, input logic blank);
    if (legal)      return GLYPH_LEGAL;
    else if (blank) return GLYPH_BLANK;
    else            return GLYPH_ILLEGAL;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex glyph table: 7-bit segment code (g..a,
// active low) to nibble, with legal/blank flags.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] i_code,
  output logic [3:0] o_value,
  output logic       o_legal,
  output logic       o_blank
);

  always_comb begin
    o_value = '0;
    o_legal = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i_code == GLYPH_TABLE[i][6:0]) begin
        o_value = 4'(i);
        o_legal = 1'b1;
      end
    end
  end

  assign o_blank = (i_code == BLANK[6:0]);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Observes a multiplexed, active-low seven-segment scan bus and recovers the
// per-digit hex value, dp, and glyph legality once each sample is stable.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS      = N_DIGITS_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   an,
  input  logic [7:0]            seg,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   dp,
  output logic [N_DIGITS-1:0]   valid,
  output logic [N_DIGITS-1:0]   err,
  output logic                  frame_done
);

  localparam int unsigned   CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [N_DIGITS-1:0]   r_an, r_an_prev;
  logic [7:0]            r_seg, r_seg_prev;
  logic [CW-1:0]         r_cnt;
  logic [N_DIGITS-1:0]   r_seen;
  logic [4*N_DIGITS-1:0] r_digits;
  logic [N_DIGITS-1:0]   r_dp, r_valid, r_err;
  logic                  r_frame_done;

  logic [N_DIGITS-1:0] w_sel;
  logic                w_selectable;
  logic                w_same;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_capture;
  logic [N_DIGITS-1:0] w_seen_nxt;
  logic [3:0]          w_value;
  logic                w_legal, w_blank;
  glyph_class_t        w_class;

  seg7_to_hex u_to_hex (
    .i_code  (r_seg[6:0]),
    .o_value (w_value),
    .o_legal (w_legal),
    .o_blank (w_blank)
  );

  // The previous-sample register gives the counter its change detector, so
  // a sample settled before edge 1 reaches STABLE_CYCLES on edge STABLE_CYCLES+1.
  always_comb begin
    w_sel        = ~r_an;
    w_selectable = $onehot(w_sel);
    w_same       = ({r_an, r_seg} == {r_an_prev, r_seg_prev});
    w_cnt_nxt    = '0;
    if (w_selectable) begin
      if (!w_same)               w_cnt_nxt = CW'(1);
      else if (r_cnt == CNT_MAX) w_cnt_nxt = CNT_MAX;
      else                       w_cnt_nxt = r_cnt + CW'(1);
    end
    w_capture  = w_selectable && (w_cnt_nxt == CNT_MAX) && (r_cnt != CNT_MAX);
    w_seen_nxt = r_seen | w_sel;
    w_class    = glyph_classify(w_legal, w_blank);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an         <= '1;
      r_seg        <= '1;
      r_an_prev    <= '1;
      r_seg_prev   <= '1;
      r_cnt        <= '0;
      r_seen       <= '0;
      r_digits     <= '0;
      r_dp         <= '0;
      r_valid      <= '0;
      r_err        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= an;
      r_seg        <= seg;
      r_an_prev    <= r_an;
      r_seg_prev   <= r_seg;
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= 1'b0;
      if (w_capture) begin
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
          if (w_sel[i]) begin
            r_dp[i]    <= ~r_seg[7];
            r_valid[i] <= (w_class == GLYPH_LEGAL);
            r_err[i]   <= (w_class == GLYPH_ILLEGAL);
            if (w_class == GLYPH_LEGAL) r_digits[4*i +: 4] <= w_value;
          end
        end
        if (&w_seen_nxt) begin
          r_frame_done <= 1'b1;
          r_seen       <= '0;
        end else begin
          r_seen <= w_seen_nxt;
        end
      end
    end
  end

  assign digits     = r_digits;
  assign dp         = r_dp;
  assign valid      = r_valid;
  assign err        = r_err;
  assign frame_done = r_frame_done;

endmodule
